// File: rtl/ft_code_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ft_code_pkg
// Brief    : Shared constants, types and helpers for the checksum encoder.
// Revision : 1.0
// ============================================================================
package ft_code_pkg;

    localparam int NUM_CH = 8;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 22;

    typedef logic [NUM_CH-1:0][3:0] weight_vec_t;

    // Element k of each vector is the weight applied to channel k.
    localparam weight_vec_t W1 = {NUM_CH{4'd1}};
    localparam weight_vec_t W2 = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

    typedef struct packed {
        logic signed [IN_W-1:0] im;
        logic signed [IN_W-1:0] re;
    } cplx_in_t;

    typedef logic [47:0] chk_t;

    function automatic chk_t pack_chk(input logic signed [OUT_W-1:0] re,
                                      input logic signed [OUT_W-1:0] im);
        return {{2{im[OUT_W-1]}}, im, {2{re[OUT_W-1]}}, re};
    endfunction

    function automatic logic signed [OUT_W-1:0] sext(input logic signed [IN_W-1:0] v);
        return {{(OUT_W-IN_W){v[IN_W-1]}}, v};
    endfunction

    // Constant weight applied as a sum of shifted copies; no multiplier.
    function automatic logic signed [OUT_W-1:0] weight_term(input logic signed [OUT_W-1:0] x,
                                                            input logic [3:0] w);
        logic signed [OUT_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < 4; b++) begin
            if (w[b]) acc = acc + (x <<< b);
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ft_weighted_sum_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ft_weighted_sum_pipe
// Brief    : Three-stage adv-gated adder tree for one channel weight vector.
// Revision : 1.0
// ============================================================================
module ft_weighted_sum_pipe
    import ft_code_pkg::*;
#(
    parameter weight_vec_t WEIGHTS = W1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_adv,
    input  logic [NUM_CH-1:0][31:0]  i_x,
    output chk_t                     o_chk
);

    localparam int c_N1 = NUM_CH / 2;
    localparam int c_N2 = NUM_CH / 4;

    logic signed [OUT_W-1:0] w_re [NUM_CH];
    logic signed [OUT_W-1:0] w_im [NUM_CH];

    logic signed [OUT_W-1:0] r_s1_re [c_N1];
    logic signed [OUT_W-1:0] r_s1_im [c_N1];
    logic signed [OUT_W-1:0] r_s2_re [c_N2];
    logic signed [OUT_W-1:0] r_s2_im [c_N2];
    chk_t                    r_s3;

    always_comb begin
        cplx_in_t s;
        s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            s       = i_x[k];
            w_re[k] = weight_term(sext(s.re), WEIGHTS[k]);
            w_im[k] = weight_term(sext(s.im), WEIGHTS[k]);
        end
    end

    // Worst-case magnitude stays below 2^21, so plain wrapping adds are exact.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < c_N1; i++) begin
                r_s1_re[i] <= '0;
                r_s1_im[i] <= '0;
            end
            for (int i = 0; i < c_N2; i++) begin
                r_s2_re[i] <= '0;
                r_s2_im[i] <= '0;
            end
            r_s3 <= '0;
        end else if (i_adv) begin
            for (int i = 0; i < c_N1; i++) begin
                r_s1_re[i] <= w_re[2*i] + w_re[2*i+1];
                r_s1_im[i] <= w_im[2*i] + w_im[2*i+1];
            end
            for (int i = 0; i < c_N2; i++) begin
                r_s2_re[i] <= r_s1_re[2*i] + r_s1_re[2*i+1];
                r_s2_im[i] <= r_s1_im[2*i] + r_s1_im[2*i+1];
            end
            r_s3 <= pack_chk(r_s2_re[0] + r_s2_re[1], r_s2_im[0] + r_s2_im[1]);
        end
    end

    assign o_chk = r_s3;

endmodule
`default_nettype wire

// File: rtl/ft_checksum_encoder.sv
`default_nettype none
// ============================================================================
// Module   : ft_checksum_encoder
// Brief    : Adds two weighted checksum channels to 8 complex data channels.
// Revision : 1.0
// ============================================================================
module ft_checksum_encoder
    import ft_code_pkg::*;
#(
    parameter int FRAME_LEN = 1024
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_CH-1:0][31:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH-1:0][31:0]  out_data,
    output chk_t                     out_chk1,
    output chk_t                     out_chk2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [15:0]              frame_cnt
);

    localparam logic [15:0] c_LAST_IDX = 16'(FRAME_LEN - 1);

    logic                     w_adv;
    logic                     w_out_hs;
    logic                     r_v1;
    logic                     r_v2;
    logic                     r_out_valid;
    logic [NUM_CH-1:0][31:0]  r_d1;
    logic [NUM_CH-1:0][31:0]  r_d2;
    logic [NUM_CH-1:0][31:0]  r_out_data;
    logic [15:0]              r_samp_cnt;
    logic [15:0]              r_frame_cnt;

    assign w_adv    = ~r_out_valid | out_ready;
    assign w_out_hs = r_out_valid & out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
            r_d1        <= '0;
            r_d2        <= '0;
            r_out_data  <= '0;
        end else if (w_adv) begin
            r_v1        <= in_valid;
            r_v2        <= r_v1;
            r_out_valid <= r_v2;
            r_d1        <= in_data;
            r_d2        <= r_d1;
            r_out_data  <= r_d2;
        end
    end

    ft_weighted_sum_pipe #(
        .WEIGHTS (W1)
    ) u_sum_c1 (
        .clk   (clk),
        .rstn  (rstn),
        .i_adv (w_adv),
        .i_x   (in_data),
        .o_chk (out_chk1)
    );

    ft_weighted_sum_pipe #(
        .WEIGHTS (W2)
    ) u_sum_c2 (
        .clk   (clk),
        .rstn  (rstn),
        .i_adv (w_adv),
        .i_x   (in_data),
        .o_chk (out_chk2)
    );

    // Counters move only on output handshakes, so bubbles and stalls leave them alone.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_samp_cnt  <= '0;
            r_frame_cnt <= '0;
        end else if (w_out_hs) begin
            if (r_samp_cnt == c_LAST_IDX) begin
                r_samp_cnt  <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_samp_cnt  <= r_samp_cnt + 16'd1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_valid & (r_samp_cnt == c_LAST_IDX);
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
